// File: rtl/rr_data_selector.sv
// Registered, handshaked channel selector: picks one requesting channel per cycle,
// either by fixed index (SEL) or by round-robin, into a valid/ready output register.
module rr_data_selector #(
    parameter  int N    = 4,
    parameter  int CH   = 4,
    localparam int SELW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CH*N-1:0]   DIN,
    input  logic [CH-1:0]     REQ,
    output logic [CH-1:0]     ACK,
    input  logic              MODE,
    input  logic [SELW-1:0]   SEL,
    output logic [N-1:0]      Y,
    output logic              VALID,
    output logic [SELW-1:0]   GRANT,
    input  logic              READY
);

    logic            free;
    logic            cand_ok;
    logic [SELW-1:0] cand;
    logic            hi_ok;
    logic            lo_ok;
    logic [SELW-1:0] hi_idx;
    logic [SELW-1:0] lo_idx;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_next;
    logic [N-1:0]    din_sel;

    assign free = !VALID || READY;

    // Round-robin splits requests at PTR: the lowest index at/above PTR wins,
    // otherwise the lowest index below PTR (the wrapped part of the search).
    always_comb begin
        cand_ok = 1'b0;
        cand    = '0;
        hi_ok   = 1'b0;
        lo_ok   = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        if (free && !RST) begin
            if (!MODE) begin
                for (int unsigned i = 0; i < CH; i++) begin
                    if (SEL == SELW'(i) && REQ[i]) begin
                        cand_ok = 1'b1;
                        cand    = SELW'(i);
                    end
                end
            end else begin
                for (int unsigned i = 0; i < CH; i++) begin
                    if (REQ[i]) begin
                        if (SELW'(i) >= ptr) begin
                            if (!hi_ok) begin
                                hi_ok  = 1'b1;
                                hi_idx = SELW'(i);
                            end
                        end else if (!lo_ok) begin
                            lo_ok  = 1'b1;
                            lo_idx = SELW'(i);
                        end
                    end
                end
                if (hi_ok) begin
                    cand_ok = 1'b1;
                    cand    = hi_idx;
                end else if (lo_ok) begin
                    cand_ok = 1'b1;
                    cand    = lo_idx;
                end
            end
        end
    end

    always_comb begin
        ACK     = '0;
        din_sel = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (cand == SELW'(i)) begin
                ACK[i]  = cand_ok;
                din_sel = DIN[i*N +: N];
            end
        end
    end

    // Wrap against CH-1 so non-power-of-two channel counts cycle correctly.
    always_comb begin
        if (cand == SELW'(CH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = cand + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Y     <= '0;
            VALID <= 1'b0;
            GRANT <= '0;
            ptr   <= '0;
        end else if (free) begin
            if (cand_ok) begin
                Y     <= din_sel;
                GRANT <= cand;
                VALID <= 1'b1;
                if (MODE) begin
                    ptr <= ptr_next;
                end
            end else begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_data_selector.md
Name: rr_data_selector

Overview:
Registered, handshaked successor to the combinational 4-way data selector. Selects one of CH requesting N-bit channels into a single output register. MODE chooses fixed selection (SEL) or round-robin arbitration. Sits between multiple data sources (ROM, input port, registers) and a single consumer such as the ALU input or the output port, with valid/ready backpressure.

Parameters:
N, 4, data width per channel
CH, 4, channel count (>=1, need not be a power of two)
SELW, (CH>1 ? $clog2(CH) : 1), width of SEL/GRANT; derived, not overridden

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  reset, synchronous, active-high
DIN  input  CH*N  packed channel data; channel i = DIN[i*N +: N]
REQ  input  CH  per-channel request; channel i holds DIN slice stable while REQ[i]=1
ACK  output  CH  combinational one-hot; ACK[i]=1 means channel i is captured at this rising edge
MODE  input  1  0 = fixed (SEL), 1 = round-robin
SEL  input  SELW  channel index in fixed mode; ignored when MODE=1
Y  output  N  registered selected data
VALID  output  1  Y/GRANT hold a captured word
GRANT  output  SELW  index of channel that produced Y
READY  input  1  consumer accepts Y when VALID&&READY at rising edge

Behaviour:
- Reset (RST=1 at edge): Y=0, VALID=0, GRANT=0, rr pointer PTR=0. While RST=1, ACK=0 regardless of REQ. Reset mid-transfer discards the held word; no ACK issued that cycle.
- Slot free: FREE = !VALID || READY.
- Candidate selection (combinational, only when FREE and !RST):
  - MODE=0: candidate = SEL if SEL<CH and REQ[SEL]=1; else none. SEL>=CH is treated as no request.
  - MODE=1: first i with REQ[i]=1 searching PTR, PTR+1, ..., CH-1, 0, ..., PTR-1 (wrap mod CH); else none.
- ACK: ACK[candidate]=1 when a candidate exists; all other bits 0. ACK is never asserted when !FREE.
- At rising edge with candidate c: Y<=DIN[c*N +: N], GRANT<=c, VALID<=1. In MODE=1 only, PTR<=(c+1) mod CH (CH=1: PTR stays 0).
- At rising edge, FREE and no candidate: VALID<=0; Y and GRANT hold their last value.
- At rising edge, !FREE (VALID=1, READY=0): Y, GRANT, VALID and PTR all hold.
- Latency: 1 cycle from ACK to VALID. Throughput: one word per cycle with READY=1. Simultaneous drain and capture (VALID&&READY plus candidate) replaces the word with no bubble.
- MODE/SEL changes take effect the same cycle, combinationally. PTR is not modified by MODE=0 grants or by a mode switch.
- Legacy equivalence: MODE=0, REQ all ones, READY=1 gives Y = DIN[SEL] delayed by one cycle, with VALID=1.
- Arithmetic: PTR increment uses wrap compare against CH-1, not power-of-two overflow.
- Source protocol: a source dropping REQ without ACK is legal; that word is simply not taken.

Test Plan:
- Legacy mux: N=4, CH=4, DIN slices 3,5,7,9; MODE=0, REQ=4'b1111, READY=1; SEL 0..3 on successive cycles -> Y=3,5,7,9 one cycle later, GRANT=SEL, VALID=1, ACK one-hot = 1<<SEL each cycle.
- Round-robin fairness: MODE=1, REQ=4'b1111 held, READY=1 for 8 cycles -> GRANT sequence 0,1,2,3,0,1,2,3; exactly one ACK bit per cycle.
- Sparse round-robin: REQ=4'b1010, PTR=0 -> GRANT 1, then 3, then 1. Then set REQ=0 -> VALID falls to 0 next edge and Y holds its last value.
- Backpressure: capture a word, then READY=0 for 3 cycles with REQ=4'b1111 -> ACK=0, Y/GRANT/VALID stable. Raise READY -> next channel is ACKed the same cycle and Y is updated with no bubble.
- Fixed-mode edge cases: CH=3, SEL=3 -> no ACK and VALID=0. SEL=2 with REQ[2]=0 -> no ACK. A MODE=0 grant of channel 2, then switch to MODE=1 -> arbitration resumes from the prior PTR.
- Reset: assert RST while VALID=1, READY=0, REQ=4'b1111 -> ACK=0 during reset. After the edge, Y=0, VALID=0, GRANT=0, and the first MODE=1 grant after release is channel 0.
